wbs_router: RTL and testbench

Parametrised Wishbone classic single-master to N-slave router: the next generation of the slave arbiter between the EPB/Wishbone bridge and the register, BRAM and sys_block slaves. It decodes the master address against per-slave windows, drives per-slave strobes, returns data from the selected slave, and terminates every cycle with exactly one ack or err. Unmapped addresses, slave errors and slave timeouts are reported to the master and recorded in status outputs.

---
 rtl/wbs_router.sv | 224 ++++++++++++++++++++++
 tb/tb_wbs_router.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wbs_router.sv
// Wishbone classic single-master to N-slave router with address-window decode,
// per-transaction timeout, and error status (count, last address, last type).
module wbs_router #(
    parameter int BUS_DATA_WIDTH = 32,
    parameter int BUS_ADDR_WIDTH = 32,
    parameter int NUM_SLAVES     = 4,
    parameter logic [NUM_SLAVES*BUS_ADDR_WIDTH-1:0] SLAVE_BASE = '0,
    parameter logic [NUM_SLAVES*BUS_ADDR_WIDTH-1:0] SLAVE_HIGH = '0,
    parameter int TIMEOUT        = 16
) (
    input  logic                                 wb_clk_i,
    input  logic                                 wb_rst_n_i,
    input  logic                                 wbm_cyc_i,
    input  logic                                 wbm_stb_i,
    input  logic                                 wbm_we_i,
    input  logic [BUS_DATA_WIDTH/8-1:0]          wbm_sel_i,
    input  logic [BUS_ADDR_WIDTH-1:0]            wbm_adr_i,
    input  logic [BUS_DATA_WIDTH-1:0]            wbm_dat_i,
    output logic [BUS_DATA_WIDTH-1:0]            wbm_dat_o,
    output logic                                 wbm_ack_o,
    output logic                                 wbm_err_o,
    output logic [NUM_SLAVES-1:0]                wbs_cyc_o,
    output logic [NUM_SLAVES-1:0]                wbs_stb_o,
    output logic                                 wbs_we_o,
    output logic [BUS_DATA_WIDTH/8-1:0]          wbs_sel_o,
    output logic [BUS_ADDR_WIDTH-1:0]            wbs_adr_o,
    output logic [BUS_DATA_WIDTH-1:0]            wbs_dat_o,
    input  logic [NUM_SLAVES*BUS_DATA_WIDTH-1:0] wbs_dat_i,
    input  logic [NUM_SLAVES-1:0]                wbs_ack_i,
    input  logic [NUM_SLAVES-1:0]                wbs_err_i,
    output logic                                 busy_o,
    output logic [15:0]                          err_count_o,
    output logic [BUS_ADDR_WIDTH-1:0]            last_err_adr_o,
    output logic [1:0]                           last_err_type_o
);
    localparam int SEL_W = BUS_DATA_WIDTH / 8;
    localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int CNT_W = $clog2(TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    localparam logic [1:0] ERR_UNMAPPED = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
    localparam logic [1:0] ERR_SLAVE    = 2'b11;

    typedef enum logic [1:0] {IDLE, ACTIVE, RESP} state_t;

    state_t                    state_q, state_d;
    logic [NUM_SLAVES-1:0]     strb_q, strb_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic                      we_q, we_d;
    logic [SEL_W-1:0]          sel_q, sel_d;
    logic [BUS_ADDR_WIDTH-1:0] adr_q, adr_d;
    logic [BUS_DATA_WIDTH-1:0] wdat_q, wdat_d;
    logic [BUS_DATA_WIDTH-1:0] rdat_q, rdat_d;
    logic                      ack_q, ack_d;
    logic                      err_q, err_d;
    logic [15:0]               err_count_q, err_count_d;
    logic [BUS_ADDR_WIDTH-1:0] err_adr_q, err_adr_d;
    logic [1:0]                err_type_q, err_type_d;

    logic [NUM_SLAVES-1:0]     hit;
    logic [BUS_DATA_WIDTH-1:0] slv_dat [NUM_SLAVES];

    generate
        for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_slave
            assign hit[gi] = (wbm_adr_i >= SLAVE_BASE[gi*BUS_ADDR_WIDTH +: BUS_ADDR_WIDTH]) &&
                             (wbm_adr_i <= SLAVE_HIGH[gi*BUS_ADDR_WIDTH +: BUS_ADDR_WIDTH]);
            assign slv_dat[gi] = wbs_dat_i[gi*BUS_DATA_WIDTH +: BUS_DATA_WIDTH];
        end
    endgenerate

    logic                  hit_any;
    logic [IDX_W-1:0]      hit_idx;
    logic [NUM_SLAVES-1:0] hit_onehot;
    logic                  rec_err;
    logic [1:0]            rec_type;
    logic [BUS_ADDR_WIDTH-1:0] rec_adr;

    // Scan downwards so the lowest matching window wins on overlap.
    always_comb begin
        hit_any    = 1'b0;
        hit_idx    = '0;
        hit_onehot = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if (hit[i]) begin
                hit_any = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
        hit_onehot[hit_idx] = hit_any;
    end

    always_comb begin
        state_d     = state_q;
        strb_d      = strb_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        sel_d       = sel_q;
        adr_d       = adr_q;
        wdat_d      = wdat_q;
        rdat_d      = rdat_q;
        ack_d       = 1'b0;
        err_d       = 1'b0;
        err_count_d = err_count_q;
        err_adr_d   = err_adr_q;
        err_type_d  = err_type_q;
        rec_err     = 1'b0;
        rec_type    = 2'b00;
        rec_adr     = adr_q;

        case (state_q)
            IDLE: begin
                if (wbm_cyc_i && wbm_stb_i) begin
                    we_d   = wbm_we_i;
                    sel_d  = wbm_sel_i;
                    adr_d  = wbm_adr_i;
                    wdat_d = wbm_dat_i;
                    if (hit_any) begin
                        idx_d   = hit_idx;
                        strb_d  = hit_onehot;
                        cnt_d   = '0;
                        state_d = ACTIVE;
                    end else begin
                        rec_err  = 1'b1;
                        rec_type = ERR_UNMAPPED;
                        rec_adr  = wbm_adr_i;
                        err_d    = 1'b1;
                        state_d  = RESP;
                    end
                end
            end
            ACTIVE: begin
                // Master abort takes precedence; the cycle vanishes without a response.
                if (!wbm_cyc_i) begin
                    strb_d  = '0;
                    state_d = IDLE;
                end else if (wbs_err_i[idx_q]) begin
                    rec_err  = 1'b1;
                    rec_type = ERR_SLAVE;
                    err_d    = 1'b1;
                    strb_d   = '0;
                    state_d  = RESP;
                end else if (wbs_ack_i[idx_q]) begin
                    rdat_d  = slv_dat[idx_q];
                    ack_d   = 1'b1;
                    strb_d  = '0;
                    state_d = RESP;
                end else if (cnt_q == CNT_LAST) begin
                    rec_err  = 1'b1;
                    rec_type = ERR_TIMEOUT;
                    err_d    = 1'b1;
                    strb_d   = '0;
                    state_d  = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                strb_d  = '0;
                state_d = IDLE;
            end
        endcase

        if (rec_err) begin
            err_count_d = (err_count_q != 16'hFFFF) ? err_count_q + 16'd1 : err_count_q;
            err_adr_d   = rec_adr;
            err_type_d  = rec_type;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q     <= IDLE;
            strb_q      <= '0;
            idx_q       <= '0;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            sel_q       <= '0;
            adr_q       <= '0;
            wdat_q      <= '0;
            rdat_q      <= '0;
            ack_q       <= 1'b0;
            err_q       <= 1'b0;
            err_count_q <= '0;
            err_adr_q   <= '0;
            err_type_q  <= '0;
        end else begin
            state_q     <= state_d;
            strb_q      <= strb_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            sel_q       <= sel_d;
            adr_q       <= adr_d;
            wdat_q      <= wdat_d;
            rdat_q      <= rdat_d;
            ack_q       <= ack_d;
            err_q       <= err_d;
            err_count_q <= err_count_d;
            err_adr_q   <= err_adr_d;
            err_type_q  <= err_type_d;
        end
    end

    assign wbs_cyc_o       = strb_q;
    assign wbs_stb_o       = strb_q;
    assign wbs_we_o        = we_q;
    assign wbs_sel_o       = sel_q;
    assign wbs_adr_o       = adr_q;
    assign wbs_dat_o       = wdat_q;
    assign wbm_dat_o       = rdat_q;
    assign wbm_ack_o       = ack_q;
    assign wbm_err_o       = err_q;
    assign busy_o          = (state_q != IDLE);
    assign err_count_o     = err_count_q;
    assign last_err_adr_o  = err_adr_q;
    assign last_err_type_o = err_type_q;

endmodule

// File: tb/tb_wbs_router.sv
// Scoreboard bench for wbs_router: directed master transactions against
// behavioural slaves with configurable wait states, hang and ack+err modes.
module tb_wbs_router;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int NS = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            m_cyc = 1'b0, m_stb = 1'b0, m_we = 1'b0;
    logic [3:0]      m_sel = 4'h0;
    logic [AW-1:0]   m_adr = '0;
    logic [DW-1:0]   m_dat = '0;
    logic [DW-1:0]   wbm_dat_o;
    logic            wbm_ack_o, wbm_err_o;
    logic [NS-1:0]   wbs_cyc_o, wbs_stb_o;
    logic            wbs_we_o;
    logic [3:0]      wbs_sel_o;
    logic [AW-1:0]   wbs_adr_o;
    logic [DW-1:0]   wbs_dat_o;
    logic [NS*DW-1:0] wbs_dat_i;
    logic [NS-1:0]   s_ack, s_err;
    logic            busy_o;
    logic [15:0]     err_count_o;
    logic [AW-1:0]   last_err_adr_o;
    logic [1:0]      last_err_type_o;

    always #5 clk = ~clk;

    wbs_router #(
        .BUS_DATA_WIDTH(DW), .BUS_ADDR_WIDTH(AW), .NUM_SLAVES(NS),
        .SLAVE_BASE({32'h0001_0000, 32'h0000_8000, 32'h0000_0100, 32'h0000_0000}),
        .SLAVE_HIGH({32'h0001_0FFF, 32'h0000_FFFF, 32'h0000_01FF, 32'h0000_00FF}),
        .TIMEOUT(10)
    ) dut (
        .wb_clk_i(clk), .wb_rst_n_i(rst_n),
        .wbm_cyc_i(m_cyc), .wbm_stb_i(m_stb), .wbm_we_i(m_we), .wbm_sel_i(m_sel),
        .wbm_adr_i(m_adr), .wbm_dat_i(m_dat), .wbm_dat_o(wbm_dat_o),
        .wbm_ack_o(wbm_ack_o), .wbm_err_o(wbm_err_o),
        .wbs_cyc_o(wbs_cyc_o), .wbs_stb_o(wbs_stb_o), .wbs_we_o(wbs_we_o),
        .wbs_sel_o(wbs_sel_o), .wbs_adr_o(wbs_adr_o), .wbs_dat_o(wbs_dat_o),
        .wbs_dat_i(wbs_dat_i), .wbs_ack_i(s_ack), .wbs_err_i(s_err),
        .busy_o(busy_o), .err_count_o(err_count_o),
        .last_err_adr_o(last_err_adr_o), .last_err_type_o(last_err_type_o)
    );

    // Slave models: mode 0 = ack after waits[i] wait states, 1 = never respond, 2 = ack+err.
    int          mode  [NS] = '{default: 0};
    int          waits [NS] = '{default: 0};
    int          scnt  [NS] = '{default: 0};
    logic [31:0] rdata [NS] = '{default: 32'h0};

    assign wbs_dat_i = {rdata[3], rdata[2], rdata[1], rdata[0]};

    always_comb begin
        s_ack = '0;
        s_err = '0;
        for (int i = 0; i < NS; i++) begin
            if (wbs_stb_o[i] && scnt[i] >= waits[i]) begin
                if (mode[i] == 0) s_ack[i] = 1'b1;
                else if (mode[i] == 2) begin
                    s_ack[i] = 1'b1;
                    s_err[i] = 1'b1;
                end
            end
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < NS; i++)
            scnt[i] <= wbs_stb_o[i] ? scnt[i] + 1 : 0;
    end

    int tests_run = 0;
    int failed = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        bit          is_err;
        logic [31:0] dat;
        logic [15:0] cnt;
        logic [1:0]  etype;
        logic [31:0] eadr;
    } exp_t;

    exp_t sb[$];

    // Monitor: every master-side termination is popped and checked.
    initial begin
        bit   prev = 1'b0;
        int   n = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev = 1'b0;
            end else begin
                if (wbm_ack_o || wbm_err_o) begin
                    n++;
                    $display("[TB] resp %0d: ack=%0b err=%0b dat=%h cnt=%h type=%0d adr=%h",
                             n, wbm_ack_o, wbm_err_o, wbm_dat_o, err_count_o,
                             last_err_type_o, last_err_adr_o);
                    chk("ack_err_exclusive", {63'd0, wbm_ack_o & wbm_err_o}, 64'd0);
                    chk("resp_not_consecutive", {63'd0, prev}, 64'd0);
                    if (sb.size() == 0) begin
                        chk("unexpected_resp", 64'd1, 64'd0);
                    end else begin
                        e = sb.pop_front();
                        chk("resp_is_err", {63'd0, wbm_err_o}, {63'd0, e.is_err});
                        chk("resp_is_ack", {63'd0, wbm_ack_o}, {63'd0, !e.is_err});
                        chk("rd_data", wbm_dat_o, e.dat);
                        chk("err_count", err_count_o, e.cnt);
                        chk("err_type", last_err_type_o, e.etype);
                        chk("err_adr", last_err_adr_o, e.eadr);
                    end
                end
                prev = wbm_ack_o | wbm_err_o;
            end
        end
    end

    function automatic exp_t mk(bit is_err, logic [31:0] dat, logic [15:0] cnt,
                                logic [1:0] etype, logic [31:0] eadr);
        exp_t e;
        e.is_err = is_err; e.dat = dat; e.cnt = cnt; e.etype = etype; e.eadr = eadr;
        return e;
    endfunction

    logic [31:0] f_adr, f_dat;
    logic        f_we;

    // Caller is on a negedge; request is sampled on the next rising edge.
    task automatic run(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                       input int e_lat, input int e_stbc, input logic [3:0] e_stbor,
                       input exp_t e);
        int lat = 0, stbc = 0;
        logic [3:0] stbor = 4'h0;
        bit got = 1'b0;
        sb.push_back(e);
        m_cyc = 1'b1; m_stb = 1'b1; m_we = we; m_adr = adr; m_dat = dat; m_sel = 4'hF;
        while (!got && lat < 40) begin
            @(negedge clk);
            lat++;
            if (wbs_stb_o != 0) begin
                if (stbc == 0) begin
                    f_adr = wbs_adr_o; f_dat = wbs_dat_o; f_we = wbs_we_o;
                end
                stbc++;
                stbor |= wbs_stb_o;
            end
            if (wbm_ack_o || wbm_err_o) got = 1'b1;
        end
        m_cyc = 1'b0; m_stb = 1'b0; m_we = 1'b0;
        chk("resp_within_bound", {63'd0, got}, 64'd1);
        chk("latency", lat, e_lat);
        chk("stb_cycles", stbc, e_stbc);
        chk("stb_pattern", stbor, e_stbor);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ctl"}, {wbs_stb_o, wbs_cyc_o, wbm_ack_o, wbm_err_o, busy_o}, 64'd0);
        chk({tag, "_rdat"}, wbm_dat_o, 64'd0);
        chk({tag, "_cnt"}, err_count_o, 64'd0);
        chk({tag, "_status"}, {last_err_adr_o, last_err_type_o}, 64'd0);
        chk({tag, "_shared"}, {wbs_adr_o, wbs_we_o, wbs_sel_o}, 64'd0);
        chk({tag, "_wdat"}, wbs_dat_o, 64'd0);
    endtask

    initial begin
        #12;
        chk_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        rdata[0] = 32'h1111_1111; waits[0] = 1;
        rdata[1] = 32'hDEAD_BEEF;
        rdata[3] = 32'h3333_0003; waits[3] = 2;

        @(negedge clk);
        run(1'b1, 32'h8, 32'h0101_0101, 3, 2, 4'b0001, mk(0, 32'h1111_1111, 0, 0, 0));
        chk("wr_adr", f_adr, 32'h8);
        chk("wr_dat", f_dat, 32'h0101_0101);
        chk("wr_we", {63'd0, f_we}, 64'd1);

        @(negedge clk);
        run(1'b0, 32'h120, 32'h0, 2, 1, 4'b0010, mk(0, 32'hDEAD_BEEF, 0, 0, 0));
        chk("rd_adr", f_adr, 32'h120);
        chk("rd_we", {63'd0, f_we}, 64'd0);

        @(negedge clk);
        run(1'b0, 32'h2000, 32'h0, 1, 0, 4'b0000, mk(1, 32'hDEAD_BEEF, 1, 2'b01, 32'h2000));

        mode[2] = 1;
        @(negedge clk);
        run(1'b0, 32'h8004, 32'h0, 11, 10, 4'b0100, mk(1, 32'hDEAD_BEEF, 2, 2'b10, 32'h8004));

        mode[2] = 2;
        @(negedge clk);
        run(1'b0, 32'h8010, 32'h0, 2, 1, 4'b0100, mk(1, 32'hDEAD_BEEF, 3, 2'b11, 32'h8010));

        @(negedge clk);
        run(1'b0, 32'h1_0ABC, 32'h0, 4, 3, 4'b1000, mk(0, 32'h3333_0003, 3, 2'b11, 32'h8010));

        @(negedge clk);
        run(1'b0, 32'h1FF, 32'h0, 2, 1, 4'b0010, mk(0, 32'hDEAD_BEEF, 3, 2'b11, 32'h8010));

        @(negedge clk);
        run(1'b0, 32'h200, 32'h0, 1, 0, 4'b0000, mk(1, 32'hDEAD_BEEF, 4, 2'b01, 32'h200));

        // Abort: slave 0 hangs, master drops cyc while ACTIVE.
        mode[0] = 1;
        @(negedge clk);
        m_cyc = 1'b1; m_stb = 1'b1; m_we = 1'b0; m_adr = 32'h10; m_sel = 4'hF;
        repeat (3) @(negedge clk);
        chk("abort_stb_before", wbs_stb_o, 4'b0001);
        chk("abort_busy_before", {63'd0, busy_o}, 64'd1);
        m_cyc = 1'b0; m_stb = 1'b0;
        @(negedge clk);
        chk("abort_stb_after", {wbs_stb_o, wbs_cyc_o, busy_o}, 64'd0);
        chk("abort_cnt", err_count_o, 64'd4);
        rdata[1] = 32'hCAFE_0001;
        run(1'b0, 32'h1F0, 32'h0, 2, 1, 4'b0010, mk(0, 32'hCAFE_0001, 4, 2'b01, 32'h200));

        // Asynchronous reset in the middle of an ACTIVE cycle.
        @(negedge clk);
        m_cyc = 1'b1; m_stb = 1'b1; m_adr = 32'h8; m_sel = 4'hF;
        repeat (2) @(negedge clk);
        chk("mid_reset_stb_before", wbs_stb_o, 4'b0001);
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero("mid_reset");
        m_cyc = 1'b0; m_stb = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        @(negedge clk);
        run(1'b0, 32'h2_0000, 32'h0, 1, 0, 4'b0000, mk(1, 32'h0, 1, 2'b01, 32'h2_0000));

        // Preload the counter near full scale, then show saturation.
        @(negedge clk);
        force dut.err_count_q = 16'hFFFD;
        @(negedge clk);
        release dut.err_count_q;
        @(negedge clk);
        chk("preload_cnt", err_count_o, 64'hFFFD);
        run(1'b0, 32'h3_0000, 32'h0, 1, 0, 4'b0000, mk(1, 32'h0, 16'hFFFE, 2'b01, 32'h3_0000));
        @(negedge clk);
        run(1'b0, 32'h3_0004, 32'h0, 1, 0, 4'b0000, mk(1, 32'h0, 16'hFFFF, 2'b01, 32'h3_0004));
        @(negedge clk);
        run(1'b0, 32'h3_0008, 32'h0, 1, 0, 4'b0000, mk(1, 32'h0, 16'hFFFF, 2'b01, 32'h3_0008));

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end
endmodule
